// File: rtl/decoder_skid_if.sv
// Handshake bundle for decoder_skid: binary index in, one-hot wire bus out.
// The slave view belongs to the decoder; the master view belongs to whoever
// drives indices and consumes the decoded bus.
interface decoder_skid_if #(
  parameter int NUM_WIRE = 16
);
  localparam int IW = $clog2(NUM_WIRE);

  logic [IW-1:0]       index_i;
  logic                index_valid_i;
  logic                index_ready_o;
  logic [NUM_WIRE-1:0] wire_o;
  logic                wire_valid_o;
  logic                wire_ready_i;
  logic                err_o;

  modport slave (
    input  index_i,
    input  index_valid_i,
    output index_ready_o,
    output wire_o,
    output wire_valid_o,
    input  wire_ready_i,
    output err_o
  );

  modport master (
    output index_i,
    output index_valid_i,
    input  index_ready_o,
    input  wire_o,
    input  wire_valid_o,
    output wire_ready_i,
    input  err_o
  );
endinterface

// File: rtl/decoder_skid.sv
// Binary-index to one-hot decoder with a 2-entry skid buffer.
// The index is decoded on acceptance and stored already in one-hot form, so
// every output comes straight from a flop and index_ready_o depends only on
// buffer occupancy, never on wire_ready_i in the same cycle.
module decoder_skid #(
  parameter int NUM_WIRE = 16
) (
  input logic           clk_i,
  input logic           arst_ni,
  decoder_skid_if.slave bus
);
  localparam logic [31:0]         NW32    = NUM_WIRE;
  localparam logic [NUM_WIRE-1:0] LSB_ONE = {{(NUM_WIRE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e              state_q;
  logic [NUM_WIRE-1:0] mainWire_q;
  logic                mainErr_q;
  logic [NUM_WIRE-1:0] skidWire_q;
  logic                skidErr_q;
  logic                valid_q;
  logic                ready_q;

  logic                push_d;
  logic                pop_d;
  logic                inRange_d;
  logic [NUM_WIRE-1:0] entryWire_d;
  logic                entryErr_d;

  // Decode the incoming index and qualify both handshakes; out-of-range
  // indices become an all-zero bus with the error flag rather than aliasing.
  always_comb begin
    inRange_d   = (32'(bus.index_i) < NW32);
    entryWire_d = inRange_d ? (LSB_ONE << bus.index_i) : '0;
    entryErr_d  = ~inRange_d;
    push_d      = bus.index_valid_i & ready_q;
    pop_d       = valid_q & bus.wire_ready_i;
  end

  // Occupancy FSM: main register feeds the outputs, skid register absorbs the
  // one extra item that can arrive while the consumer stalls.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= EMPTY;
      mainWire_q <= '0;
      mainErr_q  <= 1'b0;
      skidWire_q <= '0;
      skidErr_q  <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_d) begin
            mainWire_q <= entryWire_d;
            mainErr_q  <= entryErr_d;
            valid_q    <= 1'b1;
            ready_q    <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (push_d && pop_d) begin
            mainWire_q <= entryWire_d;
            mainErr_q  <= entryErr_d;
          end else if (push_d) begin
            skidWire_q <= entryWire_d;
            skidErr_q  <= entryErr_d;
            ready_q    <= 1'b0;
            state_q    <= TWO;
          end else if (pop_d) begin
            mainWire_q <= '0;
            mainErr_q  <= 1'b0;
            valid_q    <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        TWO: begin
          if (pop_d) begin
            mainWire_q <= skidWire_q;
            mainErr_q  <= skidErr_q;
            ready_q    <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          mainWire_q <= '0;
          mainErr_q  <= 1'b0;
          valid_q    <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= EMPTY;
        end
      endcase
    end
  end

  assign bus.wire_o        = mainWire_q;
  assign bus.err_o         = mainErr_q;
  assign bus.wire_valid_o  = valid_q;
  assign bus.index_ready_o = ready_q;
endmodule

// File: tb/tb_decoder_skid.sv
// Bench for decoder_skid: a 16-wire and a 10-wire instance share one stimulus
// stream and are compared every cycle against a depth-2 FIFO model of indices.
module tb_decoder_skid;
  logic       clk = 1'b0;
  logic       arst_n;
  logic [3:0] idxIn;
  logic       validIn;
  logic       readyIn;

  int nCompared   = 0;
  int nMismatched = 0;
  int modelQ[$];

  always #5 clk = ~clk;

  decoder_skid_if #(.NUM_WIRE(16)) bus16 ();
  decoder_skid_if #(.NUM_WIRE(10)) bus10 ();

  assign bus16.index_i       = idxIn;
  assign bus16.index_valid_i = validIn;
  assign bus16.wire_ready_i  = readyIn;
  assign bus10.index_i       = idxIn;
  assign bus10.index_valid_i = validIn;
  assign bus10.wire_ready_i  = readyIn;

  decoder_skid #(.NUM_WIRE(16)) dut16 (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus16)
  );

  decoder_skid #(.NUM_WIRE(10)) dut10 (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus10)
  );

  // One comparison: count it, report it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Position of the single set bit, or -1 if none.
  function automatic int encode(input logic [15:0] w);
    int pos;
    pos = -1;
    for (int i = 0; i < 16; i++) if (w[i]) pos = i;
    return pos;
  endfunction

  // Compare one instance against the FIFO model head and occupancy.
  task automatic compareInstance(input string tag, input int nw, input int depth,
                                 input int headIdx, input logic valid,
                                 input logic ready, input logic err,
                                 input logic [15:0] w);
    logic [15:0] expW;
    checkOutput({tag, "_valid"}, 32'(valid), 32'(depth > 0));
    checkOutput({tag, "_ready"}, 32'(ready), 32'(depth < 2));
    checkOutput({tag, "_onehot"}, 32'($countones(w) <= 1), 32'd1);
    if (depth > 0) begin
      expW = (headIdx < nw) ? (16'h0001 << headIdx) : 16'h0000;
      checkOutput({tag, "_wire"}, 32'(w), 32'(expW));
      checkOutput({tag, "_err"}, 32'(err), 32'(headIdx >= nw));
      if (headIdx < nw) checkOutput({tag, "_encode"}, encode(w), headIdx);
    end
  endtask

  // Reference model: a plain FIFO of accepted indices holding at most two.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      modelQ.delete();
    end else begin
      automatic bit doPop  = (modelQ.size() > 0) && readyIn;
      automatic bit doPush = validIn && (modelQ.size() < 2);
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(int'(idxIn));
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    automatic int depth = modelQ.size();
    automatic int head  = (depth > 0) ? modelQ[0] : 0;
    compareInstance("w16", 16, depth, head, bus16.wire_valid_o,
                    bus16.index_ready_o, bus16.err_o, bus16.wire_o);
    compareInstance("w10", 10, depth, head, bus10.wire_valid_o,
                    bus10.index_ready_o, bus10.err_o, {6'b0, bus10.wire_o});
  end

  // Drive one cycle of inputs after the falling edge, return just after the
  // following rising edge so the caller sees post-edge outputs.
  task automatic applyStimulus(input logic v, input int idx, input logic r);
    @(negedge clk);
    validIn = v;
    idxIn   = 4'(idx);
    readyIn = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n  = 1'b0;
    validIn = 1'b0;
    idxIn   = '0;
    readyIn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // Streaming, no back-pressure
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, i, 1'b1);
      if (i == 0) checkOutput("stream_first", 32'(bus16.wire_o), 32'h0001);
      if (i == 15) checkOutput("stream_last", 32'(bus16.wire_o), 32'h8000);
    end
    applyStimulus(1'b0, 0, 1'b1);

    // Back-pressure: 3, 7, 9 with consumer stalled
    applyStimulus(1'b1, 3, 1'b0);
    applyStimulus(1'b1, 7, 1'b0);
    checkOutput("bp_ready_low", 32'(bus16.index_ready_o), 32'd0);
    checkOutput("bp_hold", 32'(bus16.wire_o), 32'h0008);
    checkOutput("bp_model_depth", modelQ.size(), 2);
    applyStimulus(1'b1, 9, 1'b0);
    checkOutput("bp_still_hold", 32'(bus16.wire_o), 32'h0008);
    applyStimulus(1'b1, 9, 1'b1);
    checkOutput("bp_release", 32'(bus16.wire_o), 32'h0080);
    checkOutput("bp_release10", 32'(bus10.wire_o), 32'h0080);
    applyStimulus(1'b1, 9, 1'b1);
    checkOutput("bp_reaccept", 32'(bus16.wire_o), 32'h0200);
    applyStimulus(1'b0, 0, 1'b1);

    // Out of range on the 10-wire instance
    applyStimulus(1'b1, 12, 1'b0);
    checkOutput("oor_wire", 32'(bus10.wire_o), 32'h0);
    checkOutput("oor_err", 32'(bus10.err_o), 32'd1);
    checkOutput("oor_valid", 32'(bus10.wire_valid_o), 32'd1);
    checkOutput("oor_w16", 32'(bus16.wire_o), 32'h1000);
    applyStimulus(1'b1, 9, 1'b1);
    checkOutput("after_oor_wire", 32'(bus10.wire_o), 32'h200);
    checkOutput("after_oor_err", 32'(bus10.err_o), 32'd0);
    applyStimulus(1'b0, 0, 1'b1);

    // Simultaneous push and pop in ONE
    applyStimulus(1'b1, 4, 1'b0);
    applyStimulus(1'b1, 5, 1'b1);
    checkOutput("sim_wire", 32'(bus16.wire_o), 32'h0020);
    checkOutput("sim_ready", 32'(bus16.index_ready_o), 32'd1);
    checkOutput("sim_model_depth", modelQ.size(), 1);
    applyStimulus(1'b0, 0, 1'b1);

    // Async reset with two entries held, asserted between clock edges
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b1, 2, 1'b0);
    #2;
    arst_n  = 1'b0;
    validIn = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus16.wire_valid_o), 32'd0);
    checkOutput("rst_wire", 32'(bus16.wire_o), 32'h0);
    checkOutput("rst_err", 32'(bus16.err_o), 32'd0);
    checkOutput("rst_ready", 32'(bus16.index_ready_o), 32'd1);
    checkOutput("rst_valid10", 32'(bus10.wire_valid_o), 32'd0);
    checkOutput("rst_model_depth", modelQ.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 9) < 6));
    end
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
